// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: opcode map, sequencer state encoding and latency type.
// Used by alu_op_sequencer, its interface and the alu_op_decode lookup.
package alu_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 5;
  localparam int LAT_W  = 4;

  typedef logic [LAT_W-1:0] lat_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] OP_LOAD = 5'b00000;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_SHLA = 5'b11111;

  // Undefined opcode parked on the ALU whenever no op is in flight, so it outputs 0.
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11110;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/ALU/response signal bundle for alu_op_sequencer.
// slave: the sequencer; master: the requester, ALU and response consumer around it.
interface alu_op_sequencer_if;
  import alu_ctrl_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [OP_W-1:0]     req_op;
  logic [DATA_W-1:0]   req_ra;
  logic [DATA_W-1:0]   req_rb;
  logic                req_branch;

  logic [OP_W-1:0]     alu_op;
  logic [DATA_W-1:0]   alu_ra;
  logic [DATA_W-1:0]   alu_rb;
  logic                alu_branch;
  logic [DATA_W-1:0]   alu_hi;
  logic [DATA_W-1:0]   alu_lo;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_hi;
  logic [DATA_W-1:0]   rsp_lo;
  logic                rsp_illegal;
  logic                rsp_dz;
  logic                busy;

  modport slave (
    input  req_valid, req_op, req_ra, req_rb, req_branch,
    input  alu_hi, alu_lo,
    input  rsp_ready,
    output req_ready,
    output alu_op, alu_ra, alu_rb, alu_branch,
    output rsp_valid, rsp_hi, rsp_lo, rsp_illegal, rsp_dz,
    output busy
  );

  modport master (
    output req_valid, req_op, req_ra, req_rb, req_branch,
    output alu_hi, alu_lo,
    output rsp_ready,
    input  req_ready,
    input  alu_op, alu_ra, alu_rb, alu_branch,
    input  rsp_valid, rsp_hi, rsp_lo, rsp_illegal, rsp_dz,
    input  busy
  );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode lookup: result latency in cycles and whether the opcode is undefined.
// Undefined opcodes get BASE_LAT so they still produce a (zero) response promptly.
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 8,
  parameter int BASE_LAT = 1
) (
  input  logic [OP_W-1:0] op,
  output lat_t            lat,
  output logic            illegal
);

  always_comb begin
    lat     = lat_t'(BASE_LAT);
    illegal = 1'b0;
    case (op)
      OP_MUL: lat = lat_t'(MUL_LAT);
      OP_DIV: lat = lat_t'(DIV_LAT);
      OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR,
      OP_SHRA, OP_SHL, OP_ADDI, OP_ANDI, OP_ORI, OP_NEG, OP_NOT, OP_BR,
      OP_SHLA: ;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU op sequencer: accepts one op, holds ALU inputs for its latency, returns the result.
// Optional macro DIV_ZERO_CHECK_EN short-circuits DIV by zero to a BASE_LAT zero response with rsp_dz set.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 8,
  parameter int BASE_LAT = 1
) (
  input logic               clock,
  input logic               clear,
  alu_op_sequencer_if.slave bus
);

  state_t            state;
  lat_t              cnt;
  lat_t              dec_lat;
  lat_t              acc_lat;
  logic              dec_illegal;
  logic              div_zero;

  logic              req_ready_r;
  logic              rsp_valid_r;
  logic              busy_r;
  logic [OP_W-1:0]   op_r;
  logic [DATA_W-1:0] ra_r;
  logic [DATA_W-1:0] rb_r;
  logic              branch_r;
  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] lo_r;
  logic              illegal_r;
  logic              dz_r;
  logic              pend_illegal;
  logic              pend_dz;

  alu_op_decode #(
    .MUL_LAT  (MUL_LAT),
    .DIV_LAT  (DIV_LAT),
    .BASE_LAT (BASE_LAT)
  ) u_decode (
    .op      (bus.req_op),
    .lat     (dec_lat),
    .illegal (dec_illegal)
  );

`ifdef DIV_ZERO_CHECK_EN
  assign div_zero = (bus.req_op == OP_DIV) && (bus.req_rb == '0);
`else
  assign div_zero = 1'b0;
`endif

  assign acc_lat = div_zero ? lat_t'(BASE_LAT) : dec_lat;

  always_ff @(posedge clock) begin
    if (clear) begin
      state        <= IDLE;
      cnt          <= '0;
      req_ready_r  <= 1'b1;
      rsp_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      op_r         <= OP_NOP;
      ra_r         <= '0;
      rb_r         <= '0;
      branch_r     <= 1'b0;
      hi_r         <= '0;
      lo_r         <= '0;
      illegal_r    <= 1'b0;
      dz_r         <= 1'b0;
      pend_illegal <= 1'b0;
      pend_dz      <= 1'b0;
    end else begin
      case (state)
        // accept: freeze the ALU inputs for the whole op
        IDLE: begin
          if (bus.req_valid) begin
            op_r         <= bus.req_op;
            ra_r         <= bus.req_ra;
            rb_r         <= bus.req_rb;
            branch_r     <= bus.req_branch;
            cnt          <= acc_lat - lat_t'(1);
            pend_illegal <= dec_illegal;
            pend_dz      <= div_zero;
            req_ready_r  <= 1'b0;
            busy_r       <= 1'b1;
            state        <= EXEC;
          end
        end
        // wait out the latency; capture on the cycle the counter reads zero
        EXEC: begin
          if (cnt == '0) begin
            hi_r        <= (pend_illegal || pend_dz) ? '0 : bus.alu_hi;
            lo_r        <= (pend_illegal || pend_dz) ? '0 : bus.alu_lo;
            illegal_r   <= pend_illegal;
            dz_r        <= pend_dz;
            rsp_valid_r <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt - lat_t'(1);
          end
        end
        // hold the response; the next request is only taken after this handshake
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            op_r        <= OP_NOP;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          op_r        <= OP_NOP;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_r;
  assign bus.alu_op      = op_r;
  assign bus.alu_ra      = ra_r;
  assign bus.alu_rb      = rb_r;
  assign bus.alu_branch  = branch_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_hi      = hi_r;
  assign bus.rsp_lo      = lo_r;
  assign bus.rsp_illegal = illegal_r;
  assign bus.rsp_dz      = dz_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed cases plus random ops against a behavioural model.
// The ALU stand-in shows inverted (not yet valid) results until the op's latency has elapsed.
module tb_alu_op_sequencer;

  localparam int MUL_LAT  = 4;
  localparam int DIV_LAT  = 8;
  localparam int BASE_LAT = 1;
  localparam logic [4:0] NOP = 5'b11110;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   cur_lat = 1;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] alu_raw;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(
    .MUL_LAT  (MUL_LAT),
    .DIV_LAT  (DIV_LAT),
    .BASE_LAT (BASE_LAT)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always_ff @(posedge clock) cyc <= cyc + 1;

  // Reference ALU: what the datapath computes for each opcode (noise for undefined ones).
  function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    logic [4:0]  s;
    s = b[4:0];
    r = '0;
    case (op)
      5'd0:  r[31:0] = a + b;
      5'd3:  r[31:0] = a + b;
      5'd4:  r[31:0] = a - b;
      5'd5:  r[31:0] = a & b;
      5'd6:  r[31:0] = a | b;
      5'd7:  r[31:0] = (a >> s) | (a << (32 - s));
      5'd8:  r[31:0] = (a << s) | (a >> (32 - s));
      5'd9:  r[31:0] = a >> s;
      5'd10: r[31:0] = $signed(a) >>> s;
      5'd11: r[31:0] = a << s;
      5'd12: r[31:0] = a + b;
      5'd13: r[31:0] = a & b;
      5'd14: r[31:0] = a | b;
      5'd15: if (b != 0) r = {a % b, a / b};
      5'd16: r = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      5'd17: r[31:0] = -a;
      5'd18: r[31:0] = ~a;
      5'd19: r[31:0] = a + b;
      5'd31: r[31:0] = a << s;
      default: r = {a ^ 32'hA5A5_5A5A, b ^ 32'h5A5A_A5A5};
    endcase
    return r;
  endfunction

  function automatic bit legal_ref(input logic [4:0] op);
    return (op == 5'd0) || (op >= 5'd3 && op <= 5'd19) || (op == 5'd31);
  endfunction

  always_comb begin
    alu_raw = alu_ref(bus.alu_op, bus.alu_ra, bus.alu_rb);
    if ((cyc - acc_cyc) < (cur_lat - 1)) alu_raw = ~alu_raw;
    bus.alu_hi = alu_raw[63:32];
    bus.alu_lo = alu_raw[31:0];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic br, input int hold, input bit early, input bit poke);
    int          lat;
    int          n;
    bit          ill;
    bit          dz;
    bit          bad;
    logic [63:0] res;
    ill = !legal_ref(op);
    dz  = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
    dz  = (op == 5'd15) && (b == 0);
`endif
    if (op == 5'd16)            lat = MUL_LAT;
    else if (op == 5'd15 && !dz) lat = DIV_LAT;
    else                        lat = BASE_LAT;
    res = (ill || dz) ? 64'd0 : alu_ref(op, a, b);

    @(negedge clock);
    chk("idle_req_ready", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_ra     = a;
    bus.req_rb     = b;
    bus.req_branch = br;
    bus.rsp_ready  = early;
    cur_lat        = lat;
    @(posedge clock);
    #1 acc_cyc = cyc;
    @(negedge clock);
    bus.req_valid  = 1'b0;
    bus.req_op     = 5'($urandom);
    bus.req_ra     = $urandom;
    bus.req_rb     = $urandom;
    bus.req_branch = 1'($urandom);
    chk("alu_op", bus.alu_op, op);
    chk("alu_ra", bus.alu_ra, a);
    chk("alu_rb", bus.alu_rb, b);
    chk("alu_branch", bus.alu_branch, br);
    chk("busy", bus.busy, 1);

    n = 0;
    bad = 1'b0;
    while (!bus.rsp_valid && n < 40) begin
      if (bus.req_ready !== 1'b0 || bus.alu_op !== op || bus.alu_ra !== a || bus.busy !== 1'b1) bad = 1'b1;
      if (n == 1) bus.req_valid = 1'b1;
      if (n == 2) bus.req_valid = 1'b0;
      @(negedge clock);
      n++;
    end
    bus.req_valid = 1'b0;
    chk("exec_hold", bad, 0);
    chk("latency", n, lat);
    chk("rsp_hi", bus.rsp_hi, res[63:32]);
    chk("rsp_lo", bus.rsp_lo, res[31:0]);
    chk("rsp_illegal", bus.rsp_illegal, ill);
    chk("rsp_dz", bus.rsp_dz, dz);

    if (!early) begin
      bad = 1'b0;
      for (int h = 0; h < hold; h++) begin
        if (poke && h == 0) begin
          bus.req_valid = 1'b1;
          bus.req_op    = 5'd3;
        end
        if (poke && h == 1) bus.req_valid = 1'b0;
        @(negedge clock);
        if (bus.rsp_valid !== 1'b1 || bus.rsp_hi !== res[63:32] || bus.rsp_lo !== res[31:0] ||
            bus.req_ready !== 1'b0 || bus.alu_op !== op) bad = 1'b1;
      end
      bus.req_valid = 1'b0;
      chk("rsp_hold", bad, 0);
      bus.rsp_ready = 1'b1;
    end
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    chk("post_rsp_valid", bus.rsp_valid, 0);
    chk("post_req_ready", bus.req_ready, 1);
    chk("post_busy", bus.busy, 0);
    chk("post_alu_op", bus.alu_op, NOP);
    chk("post_hi_held", bus.rsp_hi, res[63:32]);
    chk("post_lo_held", bus.rsp_lo, res[31:0]);
    chk("post_ill_held", bus.rsp_illegal, ill);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int  bad;
    logic [4:0]  op;
    logic [31:0] b;
    int  hold;
    bus.req_valid  = 1'b0;
    bus.req_op     = 5'd0;
    bus.req_ra     = '0;
    bus.req_rb     = '0;
    bus.req_branch = 1'b0;
    bus.rsp_ready  = 1'b0;
    clear = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_alu_op", bus.alu_op, NOP);
    chk("rst_alu_ra", bus.alu_ra, 0);
    chk("rst_alu_rb", bus.alu_rb, 0);
    chk("rst_alu_branch", bus.alu_branch, 0);
    chk("rst_rsp_hi", bus.rsp_hi, 0);
    chk("rst_rsp_lo", bus.rsp_lo, 0);
    chk("rst_rsp_flags", {bus.rsp_illegal, bus.rsp_dz}, 0);

    run_op(5'd3, 32'd5, 32'd7, 1'b0, 0, 1'b0, 1'b0);
    run_op(5'd16, 32'h0001_0000, 32'h0001_0000, 1'b0, 1, 1'b0, 1'b0);
    run_op(5'd15, 32'd100, 32'd7, 1'b0, 3, 1'b0, 1'b1);
    run_op(5'd1, 32'd9, 32'd4, 1'b0, 0, 1'b0, 1'b0);
    run_op(5'd19, 32'd40, 32'd2, 1'b1, 0, 1'b1, 1'b0);
    run_op(5'd31, 32'h8000_0001, 32'd3, 1'b0, 2, 1'b0, 1'b0);
    run_op(5'd0, 32'd1000, 32'd24, 1'b0, 0, 1'b0, 1'b0);
    run_op(5'd15, 32'd55, 32'd0, 1'b0, 0, 1'b0, 1'b0);
    run_op(5'd30, 32'd1, 32'd2, 1'b0, 0, 1'b0, 1'b0);

    // clear during a MUL: accepted at edge k, clear sampled at edge k+2
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_op    = 5'd16;
    bus.req_ra    = 32'd3;
    bus.req_rb    = 32'd4;
    cur_lat       = MUL_LAT;
    @(posedge clock);
    #1 acc_cyc = cyc;
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("abort_req_ready", bus.req_ready, 1);
    chk("abort_alu_op", bus.alu_op, NOP);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_alu_ra", bus.alu_ra, 0);
    chk("abort_rsp_lo", bus.rsp_lo, 0);
    bad = 0;
    bus.rsp_ready = 1'b1;
    repeat (12) begin
      @(negedge clock);
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) bad = 1;
    end
    bus.rsp_ready = 1'b0;
    chk("abort_no_rsp", bad, 0);

    for (int i = 0; i < 30; i++) begin
      case ($urandom % 4)
        0: op = 5'd16;
        1: op = 5'd15;
        default: op = 5'($urandom);
      endcase
      b = (($urandom % 5) == 0) ? 32'd0 : $urandom;
      hold = $urandom % 4;
      run_op(op, $urandom, b, 1'($urandom), hold, (($urandom % 3) == 0), (hold >= 2) && 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle controller in front of the ALU. It accepts one operation at a time over a valid/ready request handshake and drives the ALU's Op, RA, RB and Branch inputs from registers held stable for the op's latency. After that latency it captures ResultHi/ResultLo into response registers and presents them over a valid/ready response handshake. The clocked Booth multiplier and the divider are multi-cycle, so their result wait is sequenced here rather than in the control unit.

Parameters:
MUL_LAT, 4, cycles from accept to result capture for MUL (1..15)
DIV_LAT, 8, cycles from accept to result capture for DIV (1..15)
BASE_LAT, 1, cycles from accept to capture for all other ops (1..15)

Ports:
clock  in  1  system clock, rising edge
clear  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_op  in  5  ALU opcode (ADD=00011 … SHLA=11111, LOAD=00000, BR=10011)
req_ra  in  32  operand A
req_rb  in  32  operand B
req_branch  in  1  branch-taken condition for BR
alu_op  out  5  to ALU Op
alu_ra  out  32  to ALU RA
alu_rb  out  32  to ALU RB
alu_branch  out  1  to ALU Branch
alu_hi  in  32  from ALU ResultHi
alu_lo  in  32  from ALU ResultLo
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_hi  out  32  captured high result
rsp_lo  out  32  captured low result
rsp_illegal  out  1  opcode was not a defined ALU op
rsp_dz  out  1  divide-by-zero flag (see Optional Feature)
busy  out  1  state != IDLE

Behaviour:
- Reset: on `clock` edge with `clear`=1, the block goes to IDLE.
  - req_ready=1; rsp_valid=0; busy=0.
  - rsp_hi, rsp_lo, rsp_illegal, rsp_dz, alu_ra, alu_rb and alu_branch are 0.
  - alu_op=OP_NOP (5'b11110, undefined, so the ALU outputs 0).
  - Counter is 0.
  - `clear` overrides every other input and aborts any operation in flight. No response is produced for an aborted op.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge t0: latch req_op, req_ra, req_rb and req_branch into the alu_* registers, load the counter with LAT(op)-1, go to EXEC.
  - Request inputs are ignored at all other times.
- LAT(op):
  - MUL: MUL_LAT.
  - DIV: DIV_LAT.
  - All other ops, including undefined opcodes: BASE_LAT.
- EXEC:
  - req_ready=0; alu_* outputs stay stable.
  - Counter decrements each cycle.
  - On the edge where the counter is 0, capture alu_hi→rsp_hi and alu_lo→rsp_lo, set rsp_illegal for undefined opcodes, and go to RESP.
  - rsp_valid therefore first reads 1 after edge t0+LAT(op).
- RESP:
  - rsp_valid=1; outputs are held until rsp_valid&&rsp_ready.
  - On that edge: rsp_valid←0, alu_op←OP_NOP, go to IDLE.
  - req_ready first reads 1 in the cycle after the handshake. There is no overlap of response and new request, so at most one op is in flight.
- rsp_hi, rsp_lo and the flags are held unchanged after the handshake until the next capture.
- rsp_ready=1 while not in RESP has no effect.
- Counter width is 4 bits. LAT=1 gives counter 0, so capture happens on the first EXEC edge. The counter never wraps.
- Defined opcodes:
  - 00000, 00011–10011, 11111.
  - Opcodes 00001, 00010 and 10100–11110 are illegal; the response is hi=lo=0, rsp_illegal=1.

Optional Feature:
Macro DIV_ZERO_CHECK_EN.
- Defined: a DIV accepted with req_rb==0 uses latency BASE_LAT instead of DIV_LAT. Its response has rsp_hi=rsp_lo=0 (the ALU output is not captured) and rsp_dz=1.
- Not defined: DIV always uses DIV_LAT and captures the ALU output. rsp_dz is tied to 0.

Decomposition:
- Shared package alu_ctrl_pkg:
  - the 5-bit opcode constants (ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL, ADDI, ANDI, ORI, DIV, MUL, NEG, NOT, SHLA, LOAD, BR);
  - OP_NOP;
  - the state encoding (IDLE/EXEC/RESP);
  - the 4-bit latency type.
- One sub-module, alu_op_decode: combinational opcode→{latency, illegal} lookup, parameterised by MUL_LAT, DIV_LAT and BASE_LAT.

Test Plan:
1. Reset, then ADD with ra=5, rb=7, accepted at edge k; ALU model gives lo=12 → alu_op=00011 from k; rsp_valid=1 after edge k+1; rsp_lo=12, rsp_hi=0, rsp_illegal=0.
2. MUL with ra=0x10000, rb=0x10000, MUL_LAT=4, accepted at edge k → req_ready=0 for edges k..k+4; rsp_valid after edge k+4; rsp_hi=1, rsp_lo=0.
3. DIV with ra=100, rb=7, rsp_ready held 0 for 3 cycles → rsp_valid after edge k+8; rsp_lo/rsp_hi are the captured quotient/remainder, held stable while rsp_ready=0; req_ready=0 until the cycle after the handshake; a req_valid pulse during RESP is ignored.
4. Illegal op 5'b00001 → response after BASE_LAT with hi=lo=0 and rsp_illegal=1.
5. MUL accepted, clear asserted at edge k+2 → after edge k+2: IDLE, alu_op=11110, rsp_valid never rises for that op, req_ready=1.
6. DIV_ZERO_CHECK_EN on: DIV with rb=0 → rsp_valid after edge k+1, rsp_dz=1, hi=lo=0. Macro off: same stimulus → response after edge k+8 with rsp_dz=0.
